// File: rtl/vsa_mem_if.sv
`default_nettype none
// ============================================================================
// vsa_mem_if : core fetch/data port, host program-load port and status lines
// Revision   : 1.0
// ============================================================================
interface vsa_mem_if #(
  parameter int IWIDTH = 12,
  parameter int DWIDTH = 5,
  parameter int AWIDTH = 5,
  parameter int CWIDTH = 8
);
  logic [AWIDTH-1:0] PC;
  logic [IWIDTH-1:0] instruction;
  logic [AWIDTH-1:0] ALUOutput;
  logic [DWIDTH-1:0] dataout;
  logic              wr;
  logic [DWIDTH-1:0] datain;
  logic              load_valid;
  logic [IWIDTH-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              core_hold;
  logic [CWIDTH-1:0] wr_count;

  modport slave (
    input  PC, ALUOutput, dataout, wr, load_valid, load_data, load_last,
    output instruction, datain, load_ready, core_hold, wr_count
  );

  modport master (
    output PC, ALUOutput, dataout, wr, load_valid, load_data, load_last,
    input  instruction, datain, load_ready, core_hold, wr_count
  );
endinterface
`default_nettype wire

// File: rtl/vsa_mem.sv
`default_nettype none
// ============================================================================
// vsa_mem  : instruction/data memory responder for the 12-bit VSA core
// Revision : 1.0
// ============================================================================
module vsa_mem #(
  parameter int IWIDTH = 12,
  parameter int DWIDTH = 5,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 32,
  parameter int CWIDTH = 8
) (
  input wire logic clock,
  input wire logic reset,
  vsa_mem_if.slave bus
);
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [AWIDTH-1:0] c_last_addr = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH:0]   c_depth     = (AWIDTH + 1)'(DEPTH);
  localparam logic [CWIDTH-1:0] c_cnt_max   = '1;

  state_t            r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_ptr, w_ptr_nxt;
  logic [AWIDTH:0]   r_loaded, w_loaded_nxt;
  logic [CWIDTH-1:0] r_wr_count, w_wr_count_nxt;

  logic              w_imem_we;
  logic [IWIDTH-1:0] w_imem_wdata;
  logic              w_dmem_we;
  logic [AWIDTH-1:0] w_dmem_addr;
  logic [DWIDTH-1:0] w_dmem_wdata;

  logic [IWIDTH-1:0] r_imem [DEPTH];
  logic [DWIDTH-1:0] r_dmem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= LOAD;
      r_ptr      <= '0;
      r_loaded   <= c_depth;
      r_wr_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_loaded   <= w_loaded_nxt;
      r_wr_count <= w_wr_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_loaded_nxt   = r_loaded;
    w_wr_count_nxt = r_wr_count;
    w_imem_we      = 1'b0;
    w_imem_wdata   = bus.load_data;
    w_dmem_we      = 1'b0;
    w_dmem_addr    = r_ptr;
    w_dmem_wdata   = '0;

    unique case (r_state)
      LOAD: begin
        if (bus.load_valid) begin
          w_imem_we = 1'b1;
          w_ptr_nxt = r_ptr + 1'b1;
          if (bus.load_last || (r_ptr == c_last_addr)) begin
            w_loaded_nxt = {1'b0, r_ptr} + 1'b1;
            w_ptr_nxt    = '0;
            w_state_nxt  = CLEAR;
          end
        end
      end
      CLEAR: begin
        // Zero the data array and every program slot above the loaded image,
        // which wipes any stale words left by an interrupted earlier load.
        w_dmem_we = 1'b1;
        if ({1'b0, r_ptr} >= r_loaded) begin
          w_imem_we    = 1'b1;
          w_imem_wdata = '0;
        end
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == c_last_addr) begin
          w_ptr_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.wr) begin
          w_dmem_we    = 1'b1;
          w_dmem_addr  = bus.ALUOutput;
          w_dmem_wdata = bus.dataout;
          if (r_wr_count != c_cnt_max) begin
            w_wr_count_nxt = r_wr_count + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_imem_we) begin
      r_imem[r_ptr] <= w_imem_wdata;
    end
    if (w_dmem_we) begin
      r_dmem[w_dmem_addr] <= w_dmem_wdata;
    end
  end

  // Outside RUN the core sees all-zero words, which decode as a harmless LW R0.
  assign bus.instruction = (r_state == RUN) ? r_imem[bus.PC]        : '0;
  assign bus.datain      = (r_state == RUN) ? r_dmem[bus.ALUOutput] : '0;
  assign bus.load_ready  = (r_state == LOAD);
  assign bus.core_hold   = (r_state != RUN);
  assign bus.wr_count    = r_wr_count;
endmodule
`default_nettype wire

// File: tb/tb_vsa_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vsa_mem : randomized self-checking bench with a behavioural memory model
// Revision   : 1.0
// ============================================================================
module tb_vsa_mem;
  localparam int IW    = 12;
  localparam int DW    = 5;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;

  vsa_mem_if #(.IWIDTH(IW), .DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) bus ();

  vsa_mem #(.IWIDTH(IW), .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .CWIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = loading, 1 = clearing, 2 = running
  int            m_phase = 0;
  int            m_nacc = 0;
  int            m_clear_left = 0;
  int            m_cnt = 0;
  logic [IW-1:0] m_prog [DEPTH];
  logic [IW-1:0] m_imem [DEPTH];
  logic [DW-1:0] m_dmem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0;
      m_nacc  = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.load_valid) begin
            m_prog[m_nacc] = bus.load_data;
            m_nacc++;
            if (bus.load_last || m_nacc == DEPTH) begin
              for (int i = 0; i < DEPTH; i++) begin
                m_imem[i] = (i < m_nacc) ? m_prog[i] : '0;
                m_dmem[i] = '0;
              end
              m_phase      = 1;
              m_clear_left = DEPTH;
            end
          end
        end
        1: begin
          m_clear_left--;
          if (m_clear_left == 0) m_phase = 2;
        end
        default: begin
          if (bus.wr) begin
            m_dmem[bus.ALUOutput] = bus.dataout;
            if (m_cnt < CMAX) m_cnt++;
          end
        end
      endcase
    end
    #1;
    check("load_ready", 32'(bus.load_ready), 32'(m_phase == 0));
    check("core_hold", 32'(bus.core_hold), 32'(m_phase != 2));
    check("wr_count", 32'(bus.wr_count), 32'(m_cnt));
    check("instruction", 32'(bus.instruction), (m_phase == 2) ? 32'(m_imem[bus.PC]) : 32'd0);
    check("datain", 32'(bus.datain), (m_phase == 2) ? 32'(m_dmem[bus.ALUOutput]) : 32'd0);
  end

  task automatic idle();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.wr         = 1'b0;
    bus.dataout    = '0;
    bus.ALUOutput  = '0;
    bus.PC         = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [IW-1:0] d, input logic last, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      bus.load_valid = 1'b0;
      bus.load_data  = IW'($urandom);
      bus.load_last  = 1'($urandom);
      @(negedge clock);
    end
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    @(negedge clock);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (bus.core_hold && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (bus.core_hold) check("run_timeout", 32'(bus.core_hold), 32'd0);
  endtask

  task automatic probe_instr(input int pc, input logic [IW-1:0] exp, input string name);
    @(negedge clock);
    bus.PC = AW'(pc);
    #1;
    check(name, 32'(bus.instruction), 32'(exp));
  endtask

  task automatic random_run(input int cycles, input int wr_pct);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      bus.wr        = ($urandom_range(0, 99) < wr_pct);
      bus.ALUOutput = AW'($urandom);
      bus.dataout   = DW'($urandom);
      bus.PC        = AW'($urandom);
      bus.load_valid = 1'($urandom);
      bus.load_data  = IW'($urandom);
      bus.load_last  = 1'($urandom);
    end
    @(negedge clock);
    idle();
  endtask

  initial begin
    int n;
    int len;
    logic [IW-1:0] w;
    reset = 1'b1;
    idle();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Load three words while the core hammers wr; writes must be ignored.
    bus.wr      = 1'b1;
    bus.dataout = 5'h1F;
    load_word(12'h601, 1'b0, 0);
    load_word(12'h802, 1'b0, 0);
    load_word(12'hA03, 1'b1, 0);
    check("t1_ready_low", 32'(bus.load_ready), 32'd0);
    wait_run(n);
    bus.wr = 1'b0;
    check("t1_hold_cycles", 32'(n), 32'd32);
    check("t1_wr_count", 32'(bus.wr_count), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clock);
      bus.ALUOutput = AW'(a);
      #1;
      check("t1_dmem_zero", 32'(bus.datain), 32'd0);
    end
    probe_instr(0, 12'h601, "t1_pc0");
    probe_instr(1, 12'h802, "t1_pc1");
    probe_instr(2, 12'hA03, "t1_pc2");
    probe_instr(5, 12'h000, "t1_pc5");

    // Write then read back at address 7.
    @(negedge clock);
    bus.wr        = 1'b1;
    bus.ALUOutput = 5'd7;
    bus.dataout   = 5'h15;
    #1;
    check("wr_same_cycle_old", 32'(bus.datain), 32'd0);
    @(negedge clock);
    bus.wr = 1'b0;
    #1;
    check("wr_next_cycle_new", 32'(bus.datain), 32'h15);
    check("wr_count_one", 32'(bus.wr_count), 32'd1);

    random_run(200, 50);

    // Counter saturation.
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      bus.wr        = 1'b1;
      bus.ALUOutput = AW'($urandom);
      bus.dataout   = DW'($urandom);
    end
    @(negedge clock);
    bus.wr = 1'b0;
    #1;
    check("sat_255", 32'(bus.wr_count), 32'd255);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      bus.wr = 1'b1;
    end
    @(negedge clock);
    bus.wr = 1'b0;
    #1;
    check("sat_hold", 32'(bus.wr_count), 32'd255);

    // Full 32-word load with random gaps and stray load_last on idle cycles.
    @(negedge clock);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      w = IW'(i * 3);
      load_word(w, 1'b0, $urandom_range(0, 2));
    end
    check("full_ready_low", 32'(bus.load_ready), 32'd0);
    wait_run(n);
    probe_instr(31, 12'h05D, "full_pc31");
    for (int i = 0; i < DEPTH; i++) begin
      w = IW'(i * 3);
      probe_instr(i, w, "full_pc");
    end

    // Reset mid-load, then reload a short program.
    do_reset();
    for (int i = 0; i < 10; i++) load_word(12'hFFF, 1'b0, 0);
    do_reset();
    load_word(12'h111, 1'b0, 0);
    load_word(12'h222, 1'b1, 0);
    wait_run(n);
    probe_instr(0, 12'h111, "rst_pc0");
    probe_instr(1, 12'h222, "rst_pc1");
    for (int i = 2; i < DEPTH; i++) probe_instr(i, 12'h000, "rst_pc_hi");

    // Reset mid-CLEAR, then random-length random program.
    do_reset();
    for (int i = 0; i < 20; i++) load_word(IW'($urandom), 1'b0, 0);
    load_word(12'hABC, 1'b1, 0);
    repeat (7) @(negedge clock);
    do_reset();
    len = $urandom_range(1, DEPTH);
    for (int i = 0; i < len; i++) begin
      load_word(IW'($urandom), (i == len - 1) ? 1'b1 : 1'b0, $urandom_range(0, 1));
    end
    wait_run(n);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      bus.PC = AW'(i);
    end
    random_run(150, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vsa_mem.md
# vsa_mem

Memory responder for the 12-bit very-simple-architecture core. It serves the core's instruction-fetch port (PC in, instruction out) and its data port (ALUOutput address, dataout write data, wr strobe, datain read data). Before the core runs, the block accepts a program from a host through a valid/ready load port and zero-fills both memories. It holds the core idle until the memories are ready.

## Interface
- IWIDTH, 12, instruction word width
- DWIDTH, 5, data word width
- AWIDTH, 5, address width for both memories
- DEPTH, 32, words per memory (= 2^AWIDTH)
- CWIDTH, 8, width of the write counter
- clock  input  1  master clock, rising edge
- reset  input  1  asynchronous, active-high reset
- PC  input  AWIDTH  instruction fetch address from the core
- instruction  output  IWIDTH  fetched instruction word
- ALUOutput  input  AWIDTH  data address from the core
- dataout  input  DWIDTH  store data from the core
- wr  input  1  data write strobe from the core
- datain  output  DWIDTH  load data to the core
- load_valid  input  1  host program word valid
- load_data  input  IWIDTH  host program word
- load_last  input  1  marks the final program word; qualified by load_valid
- load_ready  output  1  block accepts a program word this cycle
- core_hold  output  1  high while the core must stay in reset
- wr_count  output  CWIDTH  number of accepted core writes, saturating

## Operation
- Storage:
  - imem: DEPTH x IWIDTH.
  - dmem: DEPTH x DWIDTH.
  - Neither array is reset.
- FSM states are LOAD, CLEAR and RUN. Reset enters LOAD with ptr=0 and loaded=DEPTH.
- LOAD:
  - load_ready=1, core_hold=1.
  - Each cycle with load_valid&load_ready writes imem[ptr]<=load_data and increments ptr.
  - If load_last is set on an accepted word, or ptr=DEPTH-1 on an accepted word:
    - set loaded<=ptr+1 (6-bit, range 1..DEPTH);
    - set ptr<=0;
    - go to CLEAR.
- CLEAR:
  - load_ready=0, core_hold=1.
  - Each cycle writes dmem[ptr]<=0.
  - Also writes imem[ptr]<=0 when ptr>=loaded.
  - ptr increments. After ptr=DEPTH-1 the FSM goes to RUN.
- RUN:
  - load_ready=0, core_hold=0.
  - instruction=imem[PC] and datain=dmem[ALUOutput], both combinational.
  - On a clock edge with wr=1, dmem[ALUOutput]<=dataout.
  - wr_count increments by 1 and holds at 2^CWIDTH-1.
  - RUN is left only by reset.
- Outside RUN:
  - instruction=0 and datain=0 (all-zero word = LW R0, harmless).
  - wr is ignored and wr_count does not change.
- Read during write to the same address (RUN): datain shows the old value in the write cycle and the new value in the next cycle.
- load_valid outside LOAD is ignored. load_last is ignored when load_valid=0.
- Reset mid-LOAD or mid-CLEAR: return to LOAD with ptr=0.
  - Partially written imem words are stale.
  - A completed reload plus CLEAR zero-fills everything from loaded upward, so stale words are never visible in RUN.

## Timing
- Reset values:
  - instruction=0, datain=0, wr_count=0.
  - load_ready=1, core_hold=1.
  - state=LOAD, ptr=0.
- load_ready and core_hold are decoded from registered state. There are no combinational paths from load_valid to load_ready.
- Loading N words back-to-back takes N cycles.
- CLEAR always takes exactly DEPTH cycles.
- core_hold falls on the first RUN cycle, N+DEPTH cycles after the first accepted word.
- The core samples instruction on the edge ending its IF cycle and datain on the edge ending its MEM cycle. Combinational reads meet this with zero wait states.
- A write issued on edge t is readable through datain from cycle t+1.

## Test plan
- Program load and fetch:
  - Stimulus: after reset, load 0x601, 0x802, 0xA03 back-to-back, load_last set on the third word.
  - Required: load_ready=0 from the next cycle; core_hold=0 exactly 32 cycles later.
  - Fetch results: PC=1 gives 0x802; PC=2 gives 0xA03; PC=5 gives 0x000.
- Write then read:
  - Stimulus: in RUN, wr=1, ALUOutput=7, dataout=0x15 for one cycle.
  - Required: in the same cycle datain=0x00; in the next cycle, with ALUOutput=7, datain=0x15; wr_count=1.
- Full load:
  - Stimulus: load 32 words i*3 with load_last never set.
  - Required: the FSM goes to CLEAR after word 31; in RUN, PC=31 gives 0x05D; all imem words are retained.
- Reset mid-load:
  - Stimulus: load 10 words of 0xFFF, assert reset, then load 2 words 0x111 and 0x222 with load_last set.
  - Required: in RUN, PC=0 gives 0x111, PC=1 gives 0x222, PC=2..31 give 0x000.
- Writes ignored before RUN:
  - Stimulus: drive wr=1 with dataout=0x1F throughout LOAD and CLEAR.
  - Required: wr_count=0 and datain=0; in RUN every dmem address reads 0x00.
- Counter saturation:
  - Stimulus: 300 consecutive write cycles in RUN.
  - Required: wr_count=255 and it stays at 255.
